// File: rtl/frame_seq_pkg.sv
// rtl/frame_seq_pkg.sv - shared state, phase and colour definitions for the frame sequencer
package frame_seq_pkg;

    localparam int COLR_W = 2;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SYNC     = 3'd1,
        ST_CAPTURE  = 3'd2,
        ST_READ     = 3'd3,
        ST_CLASSIFY = 3'd4,
        ST_SEND     = 3'd5,
        ST_FAULT    = 3'd6
    } state_e;

    localparam logic [2:0] PH_SYNC     = 3'd0;
    localparam logic [2:0] PH_CAPTURE  = 3'd1;
    localparam logic [2:0] PH_READ     = 3'd2;
    localparam logic [2:0] PH_CLASSIFY = 3'd3;
    localparam logic [2:0] PH_SEND     = 3'd4;

    // Phase code reported in err_phase when the given state times out.
    function automatic logic [2:0] phase_of(input state_e s);
        case (s)
            ST_CAPTURE:  return PH_CAPTURE;
            ST_READ:     return PH_READ;
            ST_CLASSIFY: return PH_CLASSIFY;
            ST_SEND:     return PH_SEND;
            default:     return PH_SYNC;
        endcase
    endfunction

    // States that wait on an external event and are guarded by the watchdog.
    function automatic logic is_waiting(input state_e s);
        return (s == ST_SYNC) || (s == ST_CAPTURE) || (s == ST_READ) ||
               (s == ST_CLASSIFY) || (s == ST_SEND);
    endfunction

endpackage

// File: rtl/phase_watchdog.sv
// rtl/phase_watchdog.sv - per-state residency counter with expiry flag
module phase_watchdog #(
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int TMR_W          = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic run,
    output logic expire
);

    logic [TMR_W-1:0] cnt_q;
    logic [TMR_W-1:0] cnt_d;

    // Restart on every state change, otherwise count while a waiting state is active.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = (cnt_q == TMR_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/frame_sequencer.sv
// rtl/frame_sequencer.sv - camera frame sequencer: sync, capture, read, classify, send
module frame_sequencer
    import frame_seq_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int TMR_W          = 20,
    parameter int FCNT_W         = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              err_clr,
    input  logic              cam_vsync,
    input  logic              cap_done,
    input  logic              lect_done,
    input  logic              colr_done,
    input  logic [COLR_W-1:0] colr_code,
    input  logic              tx_done,
    output logic              cam_en,
    output logic              lect_go,
    output logic              colr_go,
    output logic              tx_go,
    output logic [COLR_W-1:0] color,
    output logic [FCNT_W-1:0] frame_cnt,
    output logic              busy,
    output logic              error,
    output logic [2:0]        err_phase
);

    state_e            state_q, state_d;
    logic              vsync_q, vsync_d;
    logic              cam_en_q, cam_en_d;
    logic              lect_go_q, lect_go_d;
    logic              colr_go_q, colr_go_d;
    logic              tx_go_q, tx_go_d;
    logic [COLR_W-1:0] color_q, color_d;
    logic [FCNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic              busy_q, busy_d;
    logic              error_q, error_d;
    logic [2:0]        err_phase_q, err_phase_d;
    logic              vsync_rise;
    logic              step_done;
    logic              wd_expire;

    assign vsync_rise = cam_vsync & ~vsync_q;

    phase_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TMR_W          (TMR_W)
    ) u_watchdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (state_d != state_q),
        .run    (is_waiting(state_q)),
        .expire (wd_expire)
    );

    // Next state, payload latching and registered-output values.
    always_comb begin
        state_d     = state_q;
        vsync_d     = cam_vsync;
        color_d     = color_q;
        frame_cnt_d = frame_cnt_q;
        err_phase_d = err_phase_q;
        step_done   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_SYNC;
            end
            ST_SYNC: begin
                step_done = vsync_rise;
                if (step_done) state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                step_done = cap_done;
                if (step_done) state_d = ST_READ;
            end
            ST_READ: begin
                step_done = lect_done;
                if (step_done) state_d = ST_CLASSIFY;
            end
            ST_CLASSIFY: begin
                step_done = colr_done;
                if (step_done) begin
                    state_d = ST_SEND;
                    color_d = colr_code;
                end
            end
            ST_SEND: begin
                step_done = tx_done;
                if (step_done) begin
                    frame_cnt_d = frame_cnt_q + 1'b1;
                    state_d     = start ? ST_SYNC : ST_IDLE;
                end
            end
            ST_FAULT: begin
                if (err_clr) begin
                    state_d     = ST_IDLE;
                    err_phase_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A done arriving on the expiry cycle still advances normally.
        if (is_waiting(state_q) && !step_done && wd_expire) begin
            state_d     = ST_FAULT;
            err_phase_d = phase_of(state_q);
        end

        cam_en_d  = (state_d == ST_CAPTURE);
        lect_go_d = (state_d == ST_READ)     && (state_q != ST_READ);
        colr_go_d = (state_d == ST_CLASSIFY) && (state_q != ST_CLASSIFY);
        tx_go_d   = (state_d == ST_SEND)     && (state_q != ST_SEND);
        busy_d    = (state_d != ST_IDLE) && (state_d != ST_FAULT);
        error_d   = (state_d == ST_FAULT);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            vsync_q     <= 1'b0;
            cam_en_q    <= 1'b0;
            lect_go_q   <= 1'b0;
            colr_go_q   <= 1'b0;
            tx_go_q     <= 1'b0;
            color_q     <= '0;
            frame_cnt_q <= '0;
            busy_q      <= 1'b0;
            error_q     <= 1'b0;
            err_phase_q <= '0;
        end else begin
            state_q     <= state_d;
            vsync_q     <= vsync_d;
            cam_en_q    <= cam_en_d;
            lect_go_q   <= lect_go_d;
            colr_go_q   <= colr_go_d;
            tx_go_q     <= tx_go_d;
            color_q     <= color_d;
            frame_cnt_q <= frame_cnt_d;
            busy_q      <= busy_d;
            error_q     <= error_d;
            err_phase_q <= err_phase_d;
        end
    end

    assign cam_en    = cam_en_q;
    assign lect_go   = lect_go_q;
    assign colr_go   = colr_go_q;
    assign tx_go     = tx_go_q;
    assign color     = color_q;
    assign frame_cnt = frame_cnt_q;
    assign busy      = busy_q;
    assign error     = error_q;
    assign err_phase = err_phase_q;

endmodule
